// File: rtl/instr_fetcher_pkg.sv
// Shared core encodings: scheduler (core_state) and fetcher (fetcher_state) states.
package instr_fetcher_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FETCH_IDLE     = 3'b000,
        FETCH_FETCHING = 3'b001,
        FETCH_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/instr_fetcher_buffer.sv
// Direct-mapped instruction buffer: valid/tag/data arrays, synchronous fill,
// combinational lookup, and a flush that always beats a coincident fill.
module instr_buffer #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LINES     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [DATA_BITS-1:0] i_wr_data,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic                 o_hit,
    output logic [DATA_BITS-1:0] o_rd_data
);
    localparam int IDX_W = $clog2(LINES);

    logic [LINES-1:0]     r_valid;
    logic [ADDR_BITS-1:0] r_tag  [LINES];
    logic [DATA_BITS-1:0] r_data [LINES];

    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = i_wr_addr[IDX_W-1:0];
    assign w_rd_idx = i_rd_addr[IDX_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only trusted when its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_flush) begin
            r_tag[w_wr_idx]  <= i_wr_addr;
            r_data[w_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_rd_addr);
    assign o_rd_data = r_data[w_rd_idx];

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetcher: serves FETCH from a small direct-mapped buffer, falling
// back to a single valid/ready read from program memory on a miss.
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int BUF_LINES             = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
    fetcher_state_t                   r_state;
    logic                             r_mem_read_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_read_address;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction;

    fetcher_state_t                   w_next_state;
    logic                             w_next_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] w_next_address;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_next_instruction;
    logic                             w_fill;
    logic                             w_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;

    instr_buffer #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (BUF_LINES)
    ) u_instr_buffer (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_flush   (flush),
        .i_wr_en   (w_fill),
        .i_wr_addr (r_mem_read_address),
        .i_wr_data (mem_read_data),
        .i_rd_addr (current_pc),
        .o_hit     (w_hit),
        .o_rd_data (w_hit_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= FETCH_IDLE;
            r_mem_read_valid   <= 1'b0;
            r_mem_read_address <= '0;
            r_instruction      <= '0;
        end else begin
            r_state            <= w_next_state;
            r_mem_read_valid   <= w_next_valid;
            r_mem_read_address <= w_next_address;
            r_instruction      <= w_next_instruction;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_next_valid       = r_mem_read_valid;
        w_next_address     = r_mem_read_address;
        w_next_instruction = r_instruction;
        w_fill             = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (w_hit) begin
                        w_next_instruction = w_hit_data;
                        w_next_state       = FETCH_FETCHED;
                    end else begin
                        w_next_valid   = 1'b1;
                        w_next_address = current_pc;
                        w_next_state   = FETCH_FETCHING;
                    end
                end
            end
            FETCH_FETCHING: begin
                // Address stays latched; later current_pc changes do not matter.
                if (mem_read_ready) begin
                    w_next_valid       = 1'b0;
                    w_next_instruction = mem_read_data;
                    w_fill             = 1'b1;
                    w_next_state       = FETCH_FETCHED;
                end
            end
            FETCH_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    w_next_state = FETCH_IDLE;
                end
            end
            default: begin
                w_next_state = FETCH_IDLE;
                w_next_valid = 1'b0;
            end
        endcase
    end

    assign mem_read_valid   = r_mem_read_valid;
    assign mem_read_address = r_mem_read_address;
    assign fetcher_state    = r_state;
    assign instruction      = r_instruction;

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: cold miss, hit, conflict eviction, flush,
// reset during a fetch and stray ready pulses.
module tb_instr_fetcher;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    int passed;
    int total;

    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;
    localparam logic [2:0] C_IDLE     = 3'b000;
    localparam logic [2:0] C_FETCH    = 3'b001;
    localparam logic [2:0] C_DECODE   = 3'b010;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .BUF_LINES             (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .flush            (flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic vld,
                            input logic [7:0] addr, input logic [15:0] instr);
        chk({tag, " state"}, {13'd0, fetcher_state}, {13'd0, st});
        chk({tag, " valid"}, {15'd0, mem_read_valid}, {15'd0, vld});
        chk({tag, " addr"},  {8'd0, mem_read_address}, {8'd0, addr});
        chk({tag, " instr"}, instruction, instr);
    endtask

    initial begin
        passed         = 0;
        total          = 0;
        reset          = 1'b1;
        core_state     = C_IDLE;
        current_pc     = 8'h00;
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        step();
        step();
        chk_outs("reset", S_IDLE, 1'b0, 8'h00, 16'h0000);
        reset = 1'b0;

        // Stray ready in IDLE
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        step();
        chk_outs("stray_idle", S_IDLE, 1'b0, 8'h00, 16'h0000);
        mem_read_ready = 1'b0;

        // Cold miss at 0x05, memory answers on the third request cycle
        current_pc = 8'h05;
        core_state = C_FETCH;
        step();
        chk_outs("miss05 c1", S_FETCHING, 1'b1, 8'h05, 16'h0000);
        current_pc = 8'h77;
        step();
        chk_outs("miss05 c2", S_FETCHING, 1'b1, 8'h05, 16'h0000);
        step();
        chk_outs("miss05 c3", S_FETCHING, 1'b1, 8'h05, 16'h0000);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h3A1C;
        step();
        chk_outs("miss05 done", S_FETCHED, 1'b0, 8'h05, 16'h3A1C);
        mem_read_ready = 1'b0;
        step();
        chk_outs("fetched hold", S_FETCHED, 1'b0, 8'h05, 16'h3A1C);
        // Stray ready while FETCHED
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;
        step();
        chk_outs("stray_fetched", S_FETCHED, 1'b0, 8'h05, 16'h3A1C);
        mem_read_ready = 1'b0;
        core_state     = C_DECODE;
        step();
        chk("decode->idle", {13'd0, fetcher_state}, {13'd0, S_IDLE});

        // Hit on 0x05: FETCHED one edge later, no request
        current_pc = 8'h05;
        core_state = C_FETCH;
        step();
        chk_outs("hit05", S_FETCHED, 1'b0, 8'h05, 16'h3A1C);
        core_state = C_DECODE;
        step();

        // Flush, then 0x05 must miss again
        core_state = C_IDLE;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        core_state = C_FETCH;
        step();
        chk_outs("flush miss05", S_FETCHING, 1'b1, 8'h05, 16'h3A1C);
        // Flush coincident with the fill: data delivered, line not kept
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h3A1C;
        flush          = 1'b1;
        step();
        chk_outs("flush+fill", S_FETCHED, 1'b0, 8'h05, 16'h3A1C);
        mem_read_ready = 1'b0;
        flush          = 1'b0;
        core_state     = C_DECODE;
        step();
        core_state = C_FETCH;
        step();
        chk_outs("after flush+fill miss", S_FETCHING, 1'b1, 8'h05, 16'h3A1C);
        mem_read_ready = 1'b1;
        step();
        mem_read_ready = 1'b0;
        core_state     = C_DECODE;
        step();

        // Conflict: 0x01 evicts 0x05 (same index), then 0x05 evicts 0x01
        current_pc = 8'h01;
        core_state = C_FETCH;
        step();
        chk_outs("conf miss01", S_FETCHING, 1'b1, 8'h01, 16'h3A1C);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1111;
        step();
        chk_outs("conf fill01", S_FETCHED, 1'b0, 8'h01, 16'h1111);
        mem_read_ready = 1'b0;
        core_state     = C_DECODE;
        step();
        current_pc = 8'h05;
        core_state = C_FETCH;
        step();
        chk_outs("conf miss05", S_FETCHING, 1'b1, 8'h05, 16'h1111);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h3A1C;
        step();
        chk_outs("conf fill05", S_FETCHED, 1'b0, 8'h05, 16'h3A1C);
        mem_read_ready = 1'b0;
        core_state     = C_DECODE;
        step();
        current_pc = 8'h01;
        core_state = C_FETCH;
        step();
        chk_outs("conf remiss01", S_FETCHING, 1'b1, 8'h01, 16'h3A1C);

        // Reset while the request is outstanding, then a late ready
        reset = 1'b1;
        step();
        chk_outs("reset mid", S_IDLE, 1'b0, 8'h00, 16'h0000);
        reset          = 1'b0;
        core_state     = C_IDLE;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        step();
        chk_outs("late ready", S_IDLE, 1'b0, 8'h00, 16'h0000);
        mem_read_ready = 1'b0;

        // Buffer was cleared by reset: 0x05 misses
        current_pc = 8'h05;
        core_state = C_FETCH;
        step();
        chk_outs("post-reset miss05", S_FETCHING, 1'b1, 8'h05, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetcher.md
# instr_fetcher

Per-core instruction fetcher: when the core scheduler enters FETCH, it reads the instruction at `current_pc` and presents it to the decoder. It is the consumer of the PC value produced by each thread's next-PC logic. Reads go out over the program-memory valid/ready read channel, through a small direct-mapped instruction buffer so that tight loops skip memory. Flush invalidates the buffer when program memory is reloaded.

## Interface
Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, PC / program-memory address width
- PROGRAM_MEM_DATA_BITS, 16, instruction width
- BUF_LINES, 4, instruction-buffer lines; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core_state  in  3  scheduler state (FETCH=3'b001, DECODE=3'b010)
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch
- flush  in  1  invalidate all buffer lines
- mem_read_valid  out  1  read request to program memory
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  read address
- mem_read_ready  in  1  read data valid this cycle
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  read data
- fetcher_state  out  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010
- instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction, stable while FETCHED

## Operation
- Buffer line: valid bit, full-PC tag, instruction. Index = current_pc[log2(BUF_LINES)-1:0].
- IDLE, core_state==FETCH:
  - Hit (line valid and tag==current_pc): instruction <= line data; go to FETCHED. No memory request.
  - Miss: mem_read_valid <= 1, mem_read_address <= current_pc; go to FETCHING.
- IDLE with any other core_state: hold.
- FETCHING:
  - Hold mem_read_valid and mem_read_address stable until mem_read_ready is sampled high.
  - On ready: mem_read_valid <= 0, instruction <= mem_read_data, fill the indexed line (valid=1, tag=address); go to FETCHED.
- FETCHED: hold instruction; go to IDLE when core_state==DECODE.
- mem_read_ready outside FETCHING: ignored.
- current_pc changes after the request is issued: ignored; the latched address is used.
- flush:
  - Clears all valid bits next edge, in any state.
  - Fill in the same cycle as flush: the line is not written (flush wins), but the instruction is still delivered.
  - Flush does not abort an in-flight request.
  - Flush coincident with a FETCH lookup: lookup uses pre-flush contents.
- Unused fetcher_state encodings (3'b011–3'b111): recover to IDLE with mem_read_valid=0.

## Timing
- Reset values: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, all valid bits 0.
- Hit: FETCHED at the edge after the cycle FETCH is first seen (1-cycle latency).
- Miss: mem_read_valid high the edge after FETCH is seen. FETCHED the edge after the cycle mem_read_ready is high. Minimum 2 cycles; zero-wait memory gives exactly 2.
- Exactly one request per miss. The channel is never re-issued while FETCHED.
- Reset mid-FETCHING: mem_read_valid low next edge; the memory controller must drop the outstanding read.
- All outputs are registered; no combinational path from mem_read_ready to mem_read_valid.

## Structure
- Shared core package: core_state encodings (FETCH, DECODE, EXECUTE, UPDATE, …) and fetcher_state encodings, already used by the scheduler and decoder.
- One sub-module: `instr_buffer`. It holds the valid/tag/data arrays and provides a synchronous write port, a combinational lookup, and flush. The FSM stays in instr_fetcher.

## Test plan
- Cold miss: reset, current_pc=8'h05, core_state=FETCH; memory returns 16'h3A1C after 3 cycles → one request with address 8'h05 held stable 3 cycles; instruction=16'h3A1C; FETCHED; IDLE after DECODE.
- Hit: refetch pc 8'h05 → FETCHED next edge with 16'h3A1C, mem_read_valid never asserted.
- Conflict: fetch 8'h01 then 8'h05 (same index, BUF_LINES=4), then 8'h01 again → third fetch misses and issues a request for 8'h01.
- Flush: flush pulse after the hit case, refetch 8'h05 → miss, request issued. Flush in the same cycle as ready → instruction delivered, next fetch of that PC misses.
- Reset mid-FETCHING: reset while mem_read_valid=1 → next edge valid=0, state IDLE, instruction=0; late ready ignored.
- Stray ready: mem_read_ready pulsed high in IDLE and FETCHED → no state or instruction change.
